// File: rtl/cpu_pkg.sv
// Shared CPU-core constants: default register-file geometry and architectural register indices.
package cpu_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int REG_ZERO  = 0;
endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of the register file: operand reads, result writes, destination reservations.
interface reg_file_sb_if
    import cpu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic [NRD-1:0]      rreq;
    logic                stall;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic                iss;
    logic [AW-1:0]       iaddr;
    logic [NREGS-1:0]    busy;

    modport master (
        output raddr, rreq, we, waddr, wdata, iss, iaddr,
        input  rdata, rbusy, stall, busy
    );

    modport slave (
        input  raddr, rreq, we, waddr, wdata, iss, iaddr,
        output rdata, rbusy, stall, busy
    );
endinterface

// File: rtl/reg_sb.sv
// Busy scoreboard: one reservation bit per register, set by issue, cleared by writeback, set wins.
module reg_sb
    import cpu_pkg::*;
#(
    parameter int  NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss,
    input  logic [AW-1:0]    iaddr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    output logic [NREGS-1:0] busy
);
    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_bit
            if (gi == REG_ZERO) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_live
                logic set_hit;
                logic clr_hit;
                assign set_hit = iss && (iaddr == AW'(gi));
                assign clr_hit = we && (waddr == AW'(gi));
                // A same-edge issue belongs to the newer producer, so it overrides the release.
                assign busy_next[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_reg[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy = busy_reg;
endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with combinational read ports and a busy scoreboard for RAW stalls.
// Build option REG_FILE_SB_BYPASS_EN forwards same-cycle writeback data and release to the read ports.
module reg_file_sb
    import cpu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF
) (
    input logic         clk,
    input logic         rst_n,
    reg_file_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_reg [NREGS];
    logic [NREGS-1:0] busy_vec;
    logic [NRD-1:0]   rbusy_vec;

    reg_sb #(.NREGS(NREGS)) u_sb (
        .clk   (clk),
        .rst_n (rst_n),
        .iss   (bus.iss),
        .iaddr (bus.iaddr),
        .we    (bus.we),
        .waddr (bus.waddr),
        .busy  (busy_vec)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic wr_en;
            // x0 is hardwired: its write enable is constant false.
            assign wr_en = (gi != REG_ZERO) && bus.we && (bus.waddr == AW'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_reg[gi] <= '0;
                end else if (wr_en) begin
                    regs_reg[gi] <= bus.wdata;
                end
            end
        end
    endgenerate

`ifdef REG_FILE_SB_BYPASS_EN
    logic reissue;
    assign reissue = bus.iss && (bus.iaddr == bus.waddr);
`endif

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] rd;
            logic            rb;
            assign ra = bus.raddr[gi*AW +: AW];

`ifdef REG_FILE_SB_BYPASS_EN
            logic wr_hit;
            assign wr_hit = bus.we && (bus.waddr == ra);
`endif

            always_comb begin
                rd = regs_reg[ra];
                rb = busy_vec[ra];
                if (ra == AW'(REG_ZERO)) begin
                    rd = '0;
                    rb = 1'b0;
                end
`ifdef REG_FILE_SB_BYPASS_EN
                // Writeback in flight: its data is forwarded, its release is visible now
                // unless the same register is re-reserved this very cycle.
                else if (wr_hit) begin
                    rd = bus.wdata;
                    rb = reissue ? busy_vec[ra] : 1'b0;
                end
`endif
            end

            assign bus.rdata[gi*XLEN +: XLEN] = rd;
            assign rbusy_vec[gi]              = rb;
        end
    endgenerate

    assign bus.rbusy = rbusy_vec;
    assign bus.stall = |(rbusy_vec & bus.rreq);
    assign bus.busy  = busy_vec;
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a 2-port/32-bit and a 4-port/64-bit instance share one stimulus stream
// and are compared each cycle against an array-based model of the register file rules.
module tb_reg_file_sb;
    localparam int NR = 32;

`ifdef REG_FILE_SB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        we;
    logic        iss;
    logic [4:0]  waddr;
    logic [4:0]  iaddr;
    logic [63:0] wdata;
    logic [4:0]  ra_a [2];
    logic [4:0]  ra_b [4];
    logic [1:0]  rreq_a;
    logic [3:0]  rreq_b;

    reg_file_sb_if #(.XLEN(32), .NREGS(NR), .NRD(2)) if_a ();
    reg_file_sb_if #(.XLEN(64), .NREGS(NR), .NRD(4)) if_b ();

    assign if_a.raddr = {ra_a[1], ra_a[0]};
    assign if_a.rreq  = rreq_a;
    assign if_a.we    = we;
    assign if_a.waddr = waddr;
    assign if_a.wdata = wdata[31:0];
    assign if_a.iss   = iss;
    assign if_a.iaddr = iaddr;

    assign if_b.raddr = {ra_b[3], ra_b[2], ra_b[1], ra_b[0]};
    assign if_b.rreq  = rreq_b;
    assign if_b.we    = we;
    assign if_b.waddr = waddr;
    assign if_b.wdata = wdata;
    assign if_b.iss   = iss;
    assign if_b.iaddr = iaddr;

    reg_file_sb #(.XLEN(32), .NREGS(NR), .NRD(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    reg_file_sb #(.XLEN(64), .NREGS(NR), .NRD(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    // Reference state: architectural contents and outstanding reservations.
    logic [63:0]   mem_m [NR];
    logic [NR-1:0] busy_m;
    int checks = 0;
    int errors = 0;
    int step_no = 0;

    function automatic logic [63:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return 64'd0;
        if (BYPASS && we && waddr == a) return wdata;
        return mem_m[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (BYPASS && we && waddr == a && !(iss && iaddr == a)) return 1'b0;
        return busy_m[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mem_m[i] = 64'd0;
        busy_m = '0;
    endtask

    task automatic model_update();
        if (we && waddr != 5'd0) begin
            mem_m[waddr]  = wdata;
            busy_m[waddr] = 1'b0;
        end
        if (iss && iaddr != 5'd0) busy_m[iaddr] = 1'b1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] e;
        logic        st_a;
        logic        st_b;
        st_a = 1'b0;
        st_b = 1'b0;
        for (int k = 0; k < 2; k++) begin
            e = exp_data(ra_a[k]);
            check($sformatf("a_rdata%0d(x%0d)", k, ra_a[k]), {32'd0, if_a.rdata[k*32 +: 32]}, {32'd0, e[31:0]});
            check($sformatf("a_rbusy%0d(x%0d)", k, ra_a[k]), 64'(if_a.rbusy[k]), 64'(exp_busy(ra_a[k])));
            st_a = st_a | (exp_busy(ra_a[k]) & rreq_a[k]);
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b_rdata%0d(x%0d)", k, ra_b[k]), if_b.rdata[k*64 +: 64], exp_data(ra_b[k]));
            check($sformatf("b_rbusy%0d(x%0d)", k, ra_b[k]), 64'(if_b.rbusy[k]), 64'(exp_busy(ra_b[k])));
            st_b = st_b | (exp_busy(ra_b[k]) & rreq_b[k]);
        end
        check("a_stall", 64'(if_a.stall), 64'(st_a));
        check("b_stall", 64'(if_b.stall), 64'(st_b));
        check("a_busy", 64'(if_a.busy), 64'(busy_m));
        check("b_busy", 64'(if_b.busy), 64'(busy_m));
    endtask

    // One transaction: inputs already driven; check at the falling edge, commit at the rising edge.
    task automatic step();
        @(negedge clk);
        step_no++;
        $display("[%0t] step %0d rst_n=%0b we=%0b x%0d=%h iss=%0b x%0d ra_a=%0d,%0d ra_b=%0d,%0d,%0d,%0d stall_a=%0b",
                 $time, step_no, rst_n, we, waddr, wdata, iss, iaddr, ra_a[0], ra_a[1],
                 ra_b[0], ra_b[1], ra_b[2], ra_b[3], if_a.stall);
        check_outputs();
        @(posedge clk);
        if (rst_n) model_update();
        #1;
    endtask

    task automatic idle();
        we     = 1'b0;
        iss    = 1'b0;
        waddr  = 5'd0;
        iaddr  = 5'd0;
        wdata  = 64'd0;
        rreq_a = '0;
        rreq_b = '0;
        for (int k = 0; k < 2; k++) ra_a[k] = 5'd0;
        for (int k = 0; k < 4; k++) ra_b[k] = 5'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Write x5, reserve x8, then read both back.
        we = 1'b1; waddr = 5'd5; wdata = 64'hCAFE_F00D_DEAD_BEEF; iss = 1'b1; iaddr = 5'd8;
        step();
        idle(); ra_a[0] = 5'd5; ra_a[1] = 5'd8; rreq_a = 2'b11; ra_b[0] = 5'd5; ra_b[1] = 5'd8; rreq_b = 4'b0011;
        step();

        // Asynchronous reset between edges: outputs clear immediately.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        // Edge taken with reset still low: the write and issue must be discarded.
        we = 1'b1; waddr = 5'd6; wdata = 64'h0000_0001_2345_6789; iss = 1'b1; iaddr = 5'd6;
        ra_a[1] = 5'd6; ra_b[2] = 5'd6;
        step();
        rst_n = 1'b1;
        idle(); ra_a[0] = 5'd5; ra_a[1] = 5'd6; rreq_a = 2'b11; ra_b[0] = 5'd6;
        step();

        // x0 ignores writes and reservations.
        we = 1'b1; waddr = 5'd0; wdata = 64'h0000_0000_1234_5678; iss = 1'b1; iaddr = 5'd0; rreq_a = 2'b01;
        step();
        idle(); rreq_a = 2'b11; rreq_b = 4'b1111;
        step();

        // Reserve x7, stall on it, release by writeback.
        iss = 1'b1; iaddr = 5'd7;
        step();
        idle(); ra_a[0] = 5'd7; rreq_a = 2'b01; ra_b[3] = 5'd7; rreq_b = 4'b1000;
        step();
        we = 1'b1; waddr = 5'd7; wdata = 64'h0000_0000_A5A5_A5A5;
        step();
        idle(); ra_a[0] = 5'd7; rreq_a = 2'b01;
        step();

        // Issue and writeback of x3 on the same edge: data lands, reservation remains.
        iss = 1'b1; iaddr = 5'd3; we = 1'b1; waddr = 5'd3; wdata = 64'h11;
        step();
        idle(); ra_a[0] = 5'd3; rreq_a = 2'b01; ra_b[1] = 5'd3;
        step();

        // Writeback to busy x9 while port 1 reads it.
        we = 1'b1; waddr = 5'd9; wdata = 64'h99;
        step();
        idle(); iss = 1'b1; iaddr = 5'd9;
        step();
        idle(); we = 1'b1; waddr = 5'd9; wdata = 64'h55; ra_a[1] = 5'd9; rreq_a = 2'b10; ra_b[1] = 5'd9; rreq_b = 4'b0010;
        step();
        // Same, but re-issued in that cycle: stays busy in either build.
        idle(); iss = 1'b1; iaddr = 5'd9;
        step();
        idle(); we = 1'b1; waddr = 5'd9; wdata = 64'h66; iss = 1'b1; iaddr = 5'd9; ra_a[1] = 5'd9; rreq_a = 2'b10;
        step();

        // Four independent ports, two on the same register.
        idle(); we = 1'b1; waddr = 5'd10; wdata = 64'h1010_1010_0A0A_0A0A;
        step();
        idle(); we = 1'b1; waddr = 5'd11; wdata = 64'h1111_2222_3333_4444;
        step();
        idle(); we = 1'b1; waddr = 5'd12; wdata = 64'hFFFF_0000_FFFF_0000;
        step();
        idle(); ra_b[0] = 5'd10; ra_b[1] = 5'd11; ra_b[2] = 5'd12; ra_b[3] = 5'd11;
        step();

        // Randomised traffic, biased so reads often target the register being written.
        for (int n = 0; n < 400; n++) begin
            we    = ($urandom_range(0, 1) == 1);
            waddr = 5'($urandom_range(0, NR - 1));
            wdata = {$urandom(), $urandom()};
            iss   = ($urandom_range(0, 2) == 0);
            iaddr = ($urandom_range(0, 4) == 0) ? waddr : 5'($urandom_range(0, NR - 1));
            for (int k = 0; k < 2; k++) ra_a[k] = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, NR - 1));
            for (int k = 0; k < 4; k++) ra_b[k] = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, NR - 1));
            rreq_a = 2'($urandom_range(0, 3));
            rreq_b = 4'($urandom_range(0, 15));
            step();
        end

        idle();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
